clk_sel_ctrl: RTL and testbench
===============================

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, legal range 2..255: clk cycles held busy after every sel change.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  software/system switch request valid.
REQ-005 SHALL have port req_sel  input  1  requested source: 0 = clk1, 1 = clk2.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready at posedge clk.
REQ-007 SHALL have port clk1_ok  input  1  clk1 health flag, already synchronous to clk.
REQ-008 SHALL have port clk2_ok  input  1  clk2 health flag, already synchronous to clk.
REQ-009 SHALL have port sel  output  1  registered select driving the glitchless clock mux sel input.
REQ-010 SHALL have port busy  output  1  high while a handover settles.
REQ-011 SHALL have port done  output  1  one-cycle pulse: request completed.
REQ-012 SHALL have port err  output  1  one-cycle pulse: request rejected (target clock not ok).
REQ-013 SHALL have port failover  output  1  one-cycle pulse: autonomous switch away from a failed clock.

Function
REQ-014 SHALL implement an FSM with states IDLE and SETTLE, plus a settle counter of width $clog2(SETTLE_CYCLES+1).
REQ-015 SHALL define cur_ok = (sel ? clk2_ok : clk1_ok), oth_ok = (sel ? clk1_ok : clk2_ok), fail_cond = IDLE && !cur_ok && oth_ok.
REQ-016 SHALL drive req_ready = (state == IDLE) && !fail_cond && !rst, combinationally.
REQ-017 SHALL, on acceptance with req_sel == sel, stay in IDLE, leave sel unchanged, and pulse done in the next cycle (no-op, busy stays 0).
REQ-018 SHALL, on acceptance with req_sel != sel and the target ok flag low, leave sel unchanged, stay IDLE, and pulse err in the next cycle.
REQ-019 SHALL, on acceptance with req_sel != sel and the target ok flag high, toggle sel at that edge, load counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-020 SHALL, in SETTLE, hold busy = 1 and decrement the counter each cycle; when the counter == 0, return to IDLE at the next edge. Busy therefore stays high for exactly SETTLE_CYCLES cycles.
REQ-021 SHALL assert done for exactly one cycle, coincident with the first IDLE cycle after a settling switch.
REQ-022 SHALL, when fail_cond is true at an edge, toggle sel, load the counter, enter SETTLE, and pulse failover in the next cycle. This completion SHALL NOT pulse done.
REQ-023 SHALL give fail_cond priority over a simultaneous req_valid; the request is not accepted and stays pending.
REQ-024 SHALL ignore clk1_ok/clk2_ok changes during SETTLE; fail_cond is re-evaluated in the first IDLE cycle.
REQ-025 SHALL, when both ok flags are low, hold sel, raise no failover, and reject every switch request with err.
REQ-026 SHALL never change sel while in SETTLE, and never more than once per SETTLE_CYCLES+1 cycles.
REQ-027 SHALL never assert done, err and failover together; each is a registered single-cycle pulse.

Reset
REQ-028 SHALL, while rst is high at posedge clk, force state = IDLE, sel = 0 (clk1), counter = 0, and busy = done = err = failover = 0. req_ready SHALL be 0 while rst is high.
REQ-029 SHALL, when rst is asserted mid-SETTLE, abort the settle and force sel = 0 at that edge, with no done pulse. Operation SHALL resume from IDLE on the first cycle after rst is released.

Verification
REQ-030 SHALL cover: reset, both ok=1, req_valid=1 req_sel=1 for one cycle -> sel=1 after that edge, busy=1 for 8 cycles, done=1 on cycle 9, req_ready=1 again in that same cycle.
REQ-031 SHALL cover: sel=0, req_sel=0 accepted -> done pulse next cycle, busy never asserts, sel stays 0.
REQ-032 SHALL cover: sel=0, clk2_ok=0, request req_sel=1 -> err pulse next cycle, sel stays 0, no busy.
REQ-033 SHALL cover: sel=0 idle, clk1_ok drops while clk2_ok=1 -> sel=1 next edge, failover pulse, busy for 8 cycles, no done. Both flags low instead -> sel holds 0, no pulses.
REQ-034 SHALL cover: fail_cond and req_valid in the same cycle -> req_ready=0, failover wins, and the request is accepted only after settle completes.
REQ-035 SHALL cover: rst pulsed on settle cycle 3 of a switch to 1 -> sel=0, busy=0, no done. SETTLE_CYCLES=2 -> busy for exactly 2 cycles.

Source files
------------

// File: rtl/clk_sel_ctrl.sv
// Control FSM for a glitchless clock mux. It arbitrates software switch requests
// and autonomous failover, then holds busy while the mux handover settles.
module clk_sel_ctrl #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic clk1_ok,
  input  logic clk2_ok,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic failover
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          from_req_q, from_req_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          failover_q, failover_d;

  logic cur_ok, oth_ok, tgt_ok, fail_cond, accept;

  always_comb begin
    cur_ok    = sel_q ? clk2_ok : clk1_ok;
    oth_ok    = sel_q ? clk1_ok : clk2_ok;
    tgt_ok    = req_sel ? clk2_ok : clk1_ok;
    fail_cond = (state_q == IDLE) && !cur_ok && oth_ok;
    req_ready = (state_q == IDLE) && !fail_cond && !rst;
    accept    = req_valid && req_ready;

    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    from_req_d = from_req_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    failover_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Failover outranks a pending request; the request simply waits.
        if (fail_cond) begin
          sel_d      = ~sel_q;
          cnt_d      = SETTLE_LOAD;
          state_d    = SETTLE;
          from_req_d = 1'b0;
          failover_d = 1'b1;
        end else if (accept) begin
          if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else if (!tgt_ok) begin
            err_d = 1'b1;
          end else begin
            sel_d      = req_sel;
            cnt_d      = SETTLE_LOAD;
            state_d    = SETTLE;
            from_req_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = from_req_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      from_req_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      failover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      from_req_q <= from_req_d;
      done_q     <= done_d;
      err_q      <= err_d;
      failover_q <= failover_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q == SETTLE);
  assign done     = done_q;
  assign err      = err_q;
  assign failover = failover_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: a remaining-busy-cycles model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clk_sel_ctrl;

  localparam int S = 8;

  logic clk = 1'b0;
  logic rst, req_valid, req_sel, clk1_ok, clk2_ok;
  logic req_ready, sel, busy, done, err, failover;
  logic req_ready2, sel2, busy2, done2, err2, failover2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_sel_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .clk1_ok(clk1_ok), .clk2_ok(clk2_ok),
    .sel(sel), .busy(busy), .done(done), .err(err), .failover(failover)
  );

  clk_sel_ctrl #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready2), .clk1_ok(clk1_ok), .clk2_ok(clk2_ok),
    .sel(sel2), .busy(busy2), .done(done2), .err(err2), .failover(failover2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_left counts busy cycles still to come; zero means idle.
  bit m_sel = 0;
  int m_left = 0;
  bit m_pend = 0;
  bit e_done = 0, e_err = 0, e_fo = 0;
  bit started = 0;

  function automatic bit model_fail();
    bit cur, oth;
    cur = m_sel ? clk2_ok : clk1_ok;
    oth = m_sel ? clk1_ok : clk2_ok;
    return (m_left == 0) && !cur && oth;
  endfunction

  always @(posedge clk) begin
    started = 1;
    e_done = 0; e_err = 0; e_fo = 0;
    if (rst) begin
      m_sel = 0; m_left = 0; m_pend = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_pend) e_done = 1;
    end else if (model_fail()) begin
      m_sel = !m_sel; m_left = S; m_pend = 0; e_fo = 1;
    end else if (req_valid) begin
      if (req_sel == m_sel) e_done = 1;
      else if (!(req_sel ? clk2_ok : clk1_ok)) e_err = 1;
      else begin
        m_sel = req_sel; m_left = S; m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_sel", sel, m_sel);
      chk("m_busy", busy, m_left > 0);
      chk("m_done", done, e_done);
      chk("m_err", err, e_err);
      chk("m_failover", failover, e_fo);
      chk("m_req_ready", req_ready, (m_left == 0) && !model_fail() && !rst);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  int n_busy, n_done, done_at, acc_at;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; clk1_ok = 1'b1; clk2_ok = 1'b1;
    step();
    step();
    chk("reset_sel", sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 0);
    rst = 1'b0;
    step();

    // Request switch to clk2: busy 8 cycles, done on cycle 9 with ready high
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sw_sel", sel, 1);
    n_busy = 0; done_at = 0;
    for (int i = 1; i <= 12; i++) begin
      if (busy) n_busy++;
      if (done && done_at == 0) begin
        done_at = i;
        chk("sw_ready_at_done", req_ready, 1);
      end
      step();
    end
    chk("sw_busy_len", n_busy, 8);
    chk("sw_done_cycle", done_at, 9);

    // Same-source request is a no-op with done
    do_reset();
    req_valid = 1'b1; req_sel = 1'b0;
    step();
    req_valid = 1'b0;
    chk("noop_done", done, 1);
    chk("noop_busy", busy, 0);
    chk("noop_sel", sel, 0);
    step();

    // Target not ok -> err
    clk2_ok = 1'b0;
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_sel", sel, 0);
    chk("rej_busy", busy, 0);
    clk2_ok = 1'b1;
    step();

    // clk1 fails -> failover to clk2, no done
    clk1_ok = 1'b0;
    step();
    chk("fo_sel", sel, 1);
    chk("fo_pulse", failover, 1);
    n_busy = 0; n_done = 0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) n_busy++;
      if (done) n_done++;
      step();
    end
    chk("fo_busy_len", n_busy, 8);
    chk("fo_no_done", n_done, 0);
    clk1_ok = 1'b1;

    // Both flags low: hold, no failover, switch request rejected
    do_reset();
    clk1_ok = 1'b0; clk2_ok = 1'b0;
    step();
    step();
    chk("both_low_sel", sel, 0);
    chk("both_low_fo", failover, 0);
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    chk("both_low_err", err, 1);
    chk("both_low_sel2", sel, 0);
    clk1_ok = 1'b1; clk2_ok = 1'b1;
    step();

    // Failover and request together: failover wins, request waits for idle
    do_reset();
    clk1_ok = 1'b0; req_valid = 1'b1; req_sel = 1'b0;
    #1;
    chk("prio_ready_low", req_ready, 0);
    step();
    clk1_ok = 1'b1;
    chk("prio_fo", failover, 1);
    chk("prio_sel", sel, 1);
    acc_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (req_ready) begin
        acc_at = i;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0;
    chk("prio_accept_cycle", acc_at, 9);
    chk("prio_sel_after", sel, 0);
    chk("prio_busy_after", busy, 1);
    repeat (10) step();

    // Reset on settle cycle 3 aborts the switch without done
    do_reset();
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    chk("abort_sel", sel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    step();
    chk("abort_done_after", done, 0);
    chk("abort_ready_after", req_ready, 1);
    step();

    // SETTLE_CYCLES = 2 instance: busy exactly 2 cycles, done on cycle 3
    do_reset();
    req_valid = 1'b1; req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    chk("s2_sel", sel2, 1);
    n_busy = 0; done_at = 0;
    for (int i = 1; i <= 6; i++) begin
      if (busy2) n_busy++;
      if (done2 && done_at == 0) done_at = i;
      step();
    end
    chk("s2_busy_len", n_busy, 2);
    chk("s2_done_cycle", done_at, 3);
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
